// File: rtl/pipeline_3_memory_pkg.sv
// Shared definitions for the stage-3 memory/commit block: control-bundle bit
// positions, branch condition codes, the memory FSM state type and the flag record.
package pipeline_3_memory_pkg;

  localparam int DW_DEF = 16;
  localparam int CW_DEF = 22;

  localparam int CTRL_RD_HI = 21;
  localparam int CTRL_RD_LO = 19;
  localparam int CTRL_MEMW  = 3;
  localparam int CTRL_MEMR  = 2;
  localparam int CTRL_REGW  = 1;
  localparam int CTRL_SETF  = 0;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;
  localparam logic [2:0] COND_NV = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

endpackage

// File: rtl/pipeline_3_memory_if.sv
// Data-memory request/acknowledge bus between stage 3 (master) and memory (slave).
// Handshake: master raises mem_req with stable mem_we/mem_addr/mem_wdata and holds
// it until the slave pulses mem_ack for one cycle; mem_rdata is valid with that pulse.
interface pipeline_3_memory_if #(
  parameter int DW = 16
) ();
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/pipeline_3_memory_cond_eval.sv
// Branch condition evaluator: committed {N,Z,V} plus a 3-bit code -> taken.
// Codes outside AL/EQ/NE/LT/LE never take.
module pipeline_3_memory_cond_eval
  import pipeline_3_memory_pkg::*;
(
  input  flags_t     flags,
  input  logic [2:0] cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = flags.z;
      COND_NE: taken = ~flags.z;
      COND_LT: taken = flags.n ^ flags.v;
      COND_LE: taken = (flags.n ^ flags.v) | flags.z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_3_memory.sv
// Stage 3 of the Kaiserlake pipeline: commits flags, resolves the delayed branch
// and runs data-memory loads/stores, stalling upstream while memory is busy.
module pipeline_3_memory
  import pipeline_3_memory_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       control_in,
  input  logic [DW-1:0]       result_in,
  input  logic [DW-1:0]       data_Rd_in,
  input  logic                highbit_Rm_in,
  input  logic                highbit_Rn_in,
  input  logic [5:0]          inst_type_in,
  input  logic [DW-1:0]       delayed_B_in,
  input  logic [2:0]          delayed_cond_in,
  pipeline_3_memory_if.master mem,
  output logic                stall_out,
  output logic                branch_taken,
  output logic [DW-1:0]       branch_target,
  output logic [2:0]          flags_out,
  output logic [CW-1:0]       control_out,
  output logic [DW-1:0]       wb_data,
  output logic                wb_en,
  output mem_state_t          dbg_state
);

  logic [CW-1:0] ctrl_q,      ctrl_d;
  logic [5:0]    inst_type_q, inst_type_d;
  logic [2:0]    cond_q,      cond_d;
  logic [DW-1:0] result_q,    result_d;
  logic [DW-1:0] rd_q,        rd_d;
  logic          hbrm_q,      hbrm_d;
  logic          hbrn_q,      hbrn_d;
  logic [DW-1:0] target_q,    target_d;
  logic [DW-1:0] load_buf_q,  load_buf_d;
  flags_t        flags_q,     flags_d;
  mem_state_t    state_q,     state_d;

  logic   stall;
  logic   load_en;
  logic   in_is_mem;
  logic   cur_is_mem;
  logic   cond_taken;
  flags_t flags_new;
  logic   unused_inst_type;

  assign load_en    = ~stall;
  assign in_is_mem  = control_in[CTRL_MEMR] | control_in[CTRL_MEMW];
  assign cur_is_mem = ctrl_q[CTRL_MEMR] | ctrl_q[CTRL_MEMW];

  // Flags are computed from the instruction sitting in the stage register and
  // committed on the edge that retires it (SUB/CMP overflow rule).
  always_comb begin
    flags_new.n = result_q[DW-1];
    flags_new.z = (result_q == '0);
    flags_new.v = (hbrn_q != hbrm_q) && (result_q[DW-1] != hbrn_q);
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    inst_type_d = inst_type_q;
    cond_d      = cond_q;
    result_d    = result_q;
    rd_d        = rd_q;
    hbrm_d      = hbrm_q;
    hbrn_d      = hbrn_q;
    target_d    = target_q;
    flags_d     = flags_q;
    load_buf_d  = load_buf_q;
    if (load_en) begin
      ctrl_d      = control_in;
      inst_type_d = inst_type_in;
      cond_d      = delayed_cond_in;
      result_d    = result_in;
      rd_d        = data_Rd_in;
      hbrm_d      = highbit_Rm_in;
      hbrn_d      = highbit_Rn_in;
      target_d    = delayed_B_in;
      if (ctrl_q[CTRL_SETF]) begin
        flags_d = flags_new;
      end
    end
    if ((state_q == ACCESS) && mem.mem_ack) begin
      load_buf_d = mem.mem_rdata;
    end
  end

  // State register: the FSM and the stage registers share the same reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q      <= '0;
      inst_type_q <= '0;
      cond_q      <= COND_NV;
      result_q    <= '0;
      rd_q        <= '0;
      hbrm_q      <= 1'b0;
      hbrn_q      <= 1'b0;
      target_q    <= '0;
      load_buf_q  <= '0;
      flags_q     <= '0;
      state_q     <= IDLE;
    end else begin
      ctrl_q      <= ctrl_d;
      inst_type_q <= inst_type_d;
      cond_q      <= cond_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      hbrm_q      <= hbrm_d;
      hbrn_q      <= hbrn_d;
      target_q    <= target_d;
      load_buf_q  <= load_buf_d;
      flags_q     <= flags_d;
      state_q     <= state_d;
    end
  end

  // Next state: a memory op enters ACCESS on the same edge that captures it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = in_is_mem ? ACCESS : IDLE;
      ACCESS:     state_d = mem.mem_ack ? DONE : ACCESS;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs: writeback fires once, in IDLE for ALU ops or in DONE for loads.
  always_comb begin
    stall       = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    wb_en       = 1'b0;
    wb_data     = result_q;
    case (state_q)
      IDLE: begin
        wb_en = ctrl_q[CTRL_REGW] & ~cur_is_mem;
      end
      ACCESS: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = ctrl_q[CTRL_MEMW];
      end
      DONE: begin
        wb_data = load_buf_q;
        wb_en   = ctrl_q[CTRL_REGW] & ctrl_q[CTRL_MEMR] & ~ctrl_q[CTRL_MEMW];
      end
      default: ;
    endcase
  end

  pipeline_3_memory_cond_eval u_cond_eval (
    .flags (flags_q),
    .cond  (cond_q),
    .taken (cond_taken)
  );

  assign mem.mem_addr     = result_q;
  assign mem.mem_wdata    = rd_q;
  assign stall_out        = stall;
  assign control_out      = stall ? '0 : ctrl_q;
  assign branch_taken     = ~stall & cond_taken;
  assign branch_target    = target_q;
  assign flags_out        = flags_q;
  assign dbg_state        = state_q;
  assign unused_inst_type = ^inst_type_q;

endmodule

// File: tb/tb_pipeline_3_memory.sv
// Directed bench for pipeline_3_memory: hand-computed vectors plus a writeback
// scoreboard that pops one expected value per wb_en pulse.
module tb_pipeline_3_memory;
  import pipeline_3_memory_pkg::*;

  localparam int TDW = 16;
  localparam int TCW = 22;

  localparam logic [TCW-1:0] C_NOP    = 22'h000000;
  localparam logic [TCW-1:0] C_ADD_S  = 22'h080003; // Rd=1, REGW|SETF
  localparam logic [TCW-1:0] C_CMP    = 22'h000001; // SETF only
  localparam logic [TCW-1:0] C_SUB_S  = 22'h180003; // Rd=3, REGW|SETF
  localparam logic [TCW-1:0] C_LDR    = 22'h100006; // Rd=2, MEMR|REGW
  localparam logic [TCW-1:0] C_LDR2   = 22'h280006; // Rd=5, MEMR|REGW
  localparam logic [TCW-1:0] C_ADD    = 22'h200002; // Rd=4, REGW
  localparam logic [TCW-1:0] C_STR    = 22'h000008; // MEMW
  localparam logic [TCW-1:0] C_LDST   = 22'h10000E; // MEMW|MEMR|REGW

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [TCW-1:0] control_in;
  logic [TDW-1:0] result_in;
  logic [TDW-1:0] data_Rd_in;
  logic           highbit_Rm_in;
  logic           highbit_Rn_in;
  logic [5:0]     inst_type_in;
  logic [TDW-1:0] delayed_B_in;
  logic [2:0]     delayed_cond_in;
  logic           stall_out;
  logic           branch_taken;
  logic [TDW-1:0] branch_target;
  logic [2:0]     flags_out;
  logic [TCW-1:0] control_out;
  logic [TDW-1:0] wb_data;
  logic           wb_en;
  mem_state_t     dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [TDW-1:0] exp_q[$];

  pipeline_3_memory_if #(.DW(TDW)) mem_bus ();

  always #5 clk = ~clk;

  pipeline_3_memory #(.DW(TDW), .CW(TCW)) dut (
    .clk             (clk),
    .rst             (rst),
    .control_in      (control_in),
    .result_in       (result_in),
    .data_Rd_in      (data_Rd_in),
    .highbit_Rm_in   (highbit_Rm_in),
    .highbit_Rn_in   (highbit_Rn_in),
    .inst_type_in    (inst_type_in),
    .delayed_B_in    (delayed_B_in),
    .delayed_cond_in (delayed_cond_in),
    .mem             (mem_bus),
    .stall_out       (stall_out),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .flags_out       (flags_out),
    .control_out     (control_out),
    .wb_data         (wb_data),
    .wb_en           (wb_en),
    .dbg_state       (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [TCW-1:0] ctrl, input logic [TDW-1:0] res,
                       input logic [TDW-1:0] rd, input logic rn15, input logic rm15,
                       input logic [2:0] cond, input logic [TDW-1:0] tgt);
    control_in      = ctrl;
    result_in       = res;
    data_Rd_in      = rd;
    highbit_Rn_in   = rn15;
    highbit_Rm_in   = rm15;
    inst_type_in    = ctrl[5:0];
    delayed_cond_in = cond;
    delayed_B_in    = tgt;
  endtask

  task automatic drive_idle();
    drive(C_NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, COND_NV, 16'h0000);
  endtask

  // Scoreboard: every writeback strobe must match the next expected value.
  always @(posedge clk) begin
    #2;
    if (wb_en === 1'b1) begin
      if (exp_q.size() == 0) check("wb_unexpected", wb_en, 1'b0);
      else                   check("wb_data_sb", wb_data, exp_q.pop_front());
    end
  end

  initial begin
    drive_idle();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
    rst = 1'b0;
    step();
    step();
    check("rst_mem_req", mem_bus.mem_req, 1'b0);
    check("rst_stall",   stall_out, 1'b0);
    check("rst_flags",   flags_out, 3'b000);
    check("rst_ctrl",    control_out, '0);
    check("rst_wb_en",   wb_en, 1'b0);
    check("rst_branch",  branch_taken, 1'b0);
    check("rst_state",   dbg_state, IDLE);
    rst = 1'b1;

    // Stray ack while idle must be ignored.
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hAAAA;
    step();
    mem_bus.mem_ack = 1'b0;
    check("stray_ack_req",   mem_bus.mem_req, 1'b0);
    check("stray_ack_state", dbg_state, IDLE);

    // ADD result 0 with SETF, then EQ/NE branches on the committed Z.
    exp_q.push_back(16'h0000);
    drive(C_ADD_S, 16'h0000, 16'h0000, 1'b0, 1'b0, COND_NV, 16'h0000);
    step();
    check("add_wb_en",     wb_en, 1'b1);
    check("add_wb_data",   wb_data, 16'h0000);
    check("add_ctrl",      control_out, C_ADD_S);
    check("add_flags_old", flags_out, 3'b000);
    drive(C_NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, COND_EQ, 16'h1234);
    step();
    check("add_flags",  flags_out, 3'b010);
    check("beq_taken",  branch_taken, 1'b1);
    check("beq_target", branch_target, 16'h1234);
    drive(C_NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, COND_NE, 16'h1300);
    step();
    check("bne_taken", branch_taken, 1'b0);

    // CMP 0x7FFF - 0x8000 = 0xFFFF: N=1 Z=0 V=1.
    drive(C_CMP, 16'hFFFF, 16'h0000, 1'b0, 1'b1, COND_NV, 16'h0000);
    step();
    check("cmp_wb_en", wb_en, 1'b0);
    drive(C_NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, COND_LT, 16'h2000);
    step();
    check("cmp_flags", flags_out, 3'b101);
    check("blt_cmp",   branch_taken, 1'b0);
    drive(C_NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, COND_LE, 16'h2040);
    step();
    check("ble_cmp", branch_taken, 1'b0);
    drive(C_NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, COND_AL, 16'h2100);
    step();
    check("bal_taken", branch_taken, 1'b1);
    drive(C_NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b101, 16'h2140);
    step();
    check("bnever", branch_taken, 1'b0);

    // SUB result 0x8001, Rn negative, Rm positive: N=1 Z=0 V=0 -> LT taken.
    exp_q.push_back(16'h8001);
    drive(C_SUB_S, 16'h8001, 16'h0000, 1'b1, 1'b0, COND_NV, 16'h0000);
    step();
    drive(C_NOP, 16'h0000, 16'h0000, 1'b0, 1'b0, COND_LT, 16'h2200);
    step();
    check("sub_flags", flags_out, 3'b100);
    check("blt_sub",   branch_taken, 1'b1);

    // LDR 0x0040 with ack in the third ACCESS cycle; carries an AL branch.
    drive(C_LDR, 16'h0040, 16'h0000, 1'b0, 1'b0, COND_AL, 16'h0300);
    step();
    check("ldr_req1",    mem_bus.mem_req, 1'b1);
    check("ldr_stall1",  stall_out, 1'b1);
    check("ldr_we",      mem_bus.mem_we, 1'b0);
    check("ldr_addr",    mem_bus.mem_addr, 16'h0040);
    check("ldr_bubble",  control_out, '0);
    check("ldr_wb_acc",  wb_en, 1'b0);
    check("ldr_br_stall", branch_taken, 1'b0);
    drive(C_ADD, 16'h0055, 16'h0000, 1'b0, 1'b0, COND_NV, 16'h0000);
    step();
    check("ldr_req2",   mem_bus.mem_req, 1'b1);
    check("ldr_stall2", stall_out, 1'b1);
    step();
    check("ldr_req3",   mem_bus.mem_req, 1'b1);
    check("ldr_stall3", stall_out, 1'b1);
    exp_q.push_back(16'hBEEF);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hBEEF;
    step();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0000;
    check("ldr_done_req",   mem_bus.mem_req, 1'b0);
    check("ldr_done_stall", stall_out, 1'b0);
    check("ldr_done_state", dbg_state, DONE);
    check("ldr_wb_en",      wb_en, 1'b1);
    check("ldr_wb_data",    wb_data, 16'hBEEF);
    check("ldr_done_ctrl",  control_out, C_LDR);
    check("ldr_br_done",    branch_taken, 1'b1);
    exp_q.push_back(16'h0055);
    step();
    check("add_after_ldr_state", dbg_state, IDLE);
    check("add_after_ldr_data",  wb_data, 16'h0055);
    check("add_after_ldr_br",    branch_taken, 1'b0);
    drive_idle();

    // STR 0x1234 -> 0x0010 with ack on the first ACCESS cycle.
    drive(C_STR, 16'h0010, 16'h1234, 1'b0, 1'b0, COND_NV, 16'h0000);
    step();
    check("str_we",    mem_bus.mem_we, 1'b1);
    check("str_addr",  mem_bus.mem_addr, 16'h0010);
    check("str_wdata", mem_bus.mem_wdata, 16'h1234);
    check("str_stall", stall_out, 1'b1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hDEAD;
    drive_idle();
    step();
    mem_bus.mem_ack = 1'b0;
    check("str_done_stall", stall_out, 1'b0);
    check("str_done_req",   mem_bus.mem_req, 1'b0);
    check("str_wb_en",      wb_en, 1'b0);
    step();

    // MEMR and MEMW both set behaves as a store.
    drive(C_LDST, 16'h0020, 16'h5678, 1'b0, 1'b0, COND_NV, 16'h0000);
    step();
    check("ldst_we", mem_bus.mem_we, 1'b1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h9999;
    drive_idle();
    step();
    mem_bus.mem_ack = 1'b0;
    check("ldst_wb_en", wb_en, 1'b0);
    step();

    // Back-to-back loads: DONE goes straight to ACCESS.
    drive(C_LDR, 16'h0100, 16'h0000, 1'b0, 1'b0, COND_NV, 16'h0000);
    step();
    check("b2b_req1",  mem_bus.mem_req, 1'b1);
    check("b2b_addr1", mem_bus.mem_addr, 16'h0100);
    exp_q.push_back(16'h1111);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h1111;
    drive(C_LDR2, 16'h0102, 16'h0000, 1'b0, 1'b0, COND_NV, 16'h0000);
    step();
    mem_bus.mem_ack = 1'b0;
    check("b2b_done1_wb", wb_en, 1'b1);
    check("b2b_done1_req", mem_bus.mem_req, 1'b0);
    step();
    check("b2b_state2", dbg_state, ACCESS);
    check("b2b_req2",   mem_bus.mem_req, 1'b1);
    check("b2b_addr2",  mem_bus.mem_addr, 16'h0102);
    check("b2b_wb_acc", wb_en, 1'b0);
    drive_idle();
    exp_q.push_back(16'h2222);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h2222;
    step();
    mem_bus.mem_ack = 1'b0;
    check("b2b_done2_data", wb_data, 16'h2222);
    step();
    check("b2b_idle", dbg_state, IDLE);
    check("b2b_idle_wb", wb_en, 1'b0);

    // Reset in the middle of an access drops the request; late ack ignored.
    check("pre_rst_flags", flags_out, 3'b100);
    drive(C_LDR, 16'h0200, 16'h0000, 1'b0, 1'b0, COND_NV, 16'h0000);
    step();
    check("mid_req", mem_bus.mem_req, 1'b1);
    rst = 1'b0;
    step();
    check("mid_rst_req",   mem_bus.mem_req, 1'b0);
    check("mid_rst_stall", stall_out, 1'b0);
    check("mid_rst_flags", flags_out, 3'b000);
    check("mid_rst_ctrl",  control_out, '0);
    check("mid_rst_wb",    wb_en, 1'b0);
    rst = 1'b1;
    drive_idle();
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h7777;
    step();
    mem_bus.mem_ack = 1'b0;
    check("late_ack_req",   mem_bus.mem_req, 1'b0);
    check("late_ack_stall", stall_out, 1'b0);
    check("late_ack_wb",    wb_en, 1'b0);
    check("late_ack_state", dbg_state, IDLE);

    step();
    step();
    #5;
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
